// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master shift engine fed by an external clock divider.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first shifting on mosi and rx_data.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  sync_rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk_in,
  output logic                  clk_en_out,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int CNT_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                  r_cpol_l;
  logic                  r_cpha_l;
  logic                  r_sclk_q;
  logic                  r_mosi;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [CNT_W-1:0]      r_edge_cnt;

  logic                  w_accept;
  logic                  w_edge;
  logic                  w_lead;
  logic                  w_trail;
  logic                  w_last_edge;
  logic                  w_sample;
  logic                  w_advance;
  logic                  w_tx_first;
  logic                  w_tx_cur;
  logic                  w_tx_next;
  logic [DATA_WIDTH-1:0] w_tx_shifted;
  logic [DATA_WIDTH-1:0] w_rx_shifted;
  logic [DATA_WIDTH-1:0] w_rx_next;

  // Bit ordering: the "current" bit of r_tx_shift is the one presented on mosi.
`ifdef SPI_LSB_FIRST_EN
  assign w_tx_first   = tx_data[0];
  assign w_tx_cur     = r_tx_shift[0];
  assign w_tx_next    = r_tx_shift[1];
  assign w_tx_shifted = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
  assign w_rx_shifted = {miso, r_rx_shift[DATA_WIDTH-1:1]};
`else
  assign w_tx_first   = tx_data[DATA_WIDTH-1];
  assign w_tx_cur     = r_tx_shift[DATA_WIDTH-1];
  assign w_tx_next    = r_tx_shift[DATA_WIDTH-2];
  assign w_tx_shifted = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign w_rx_shifted = {r_rx_shift[DATA_WIDTH-2:0], miso};
`endif

  assign w_accept    = (r_state == S_IDLE) && tx_valid;
  assign w_edge      = (r_state == S_SHIFT) && (sclk_in != r_sclk_q);
  assign w_lead      = w_edge && (sclk_in != r_cpol_l);
  assign w_trail     = w_edge && (sclk_in == r_cpol_l);
  assign w_last_edge = w_edge && (r_edge_cnt == LAST_EDGE);
  assign w_sample    = r_cpha_l ? w_trail : w_lead;
  // In CPHA=0 the final trailing edge ends the word, so no further bit is shifted.
  assign w_advance   = r_cpha_l ? w_lead : (w_trail && !w_last_edge);
  assign w_rx_next   = w_sample ? w_rx_shifted : r_rx_shift;

  assign busy    = (r_state != S_IDLE);
  assign sclk    = (r_state == S_SHIFT) ? sclk_in : r_cpol_l;
  assign mosi    = r_mosi;
  assign rx_data = r_rx_data;

  always_ff @(posedge clk_in) begin
    if (sync_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    tx_ready     = 1'b0;
    cs_n         = 1'b1;
    clk_en_out   = 1'b0;
    rx_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        cs_n         = 1'b0;
        clk_en_out   = 1'b1;
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        cs_n       = 1'b0;
        clk_en_out = 1'b1;
        if (w_last_edge) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        rx_valid     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (sync_rst) begin
      r_cpol_l   <= cpol;
      r_cpha_l   <= 1'b0;
      r_sclk_q   <= cpol;
      r_mosi     <= 1'b0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_sclk_q <= sclk_in;
      // The idle level tracks cpol while idle and freezes once a word is accepted.
      if (r_state == S_IDLE) begin
        r_cpol_l <= cpol;
      end
      if (w_accept) begin
        r_cpha_l   <= cpha;
        r_tx_shift <= tx_data;
        r_mosi     <= w_tx_first;
        r_rx_shift <= '0;
        r_edge_cnt <= '0;
      end
      if (w_edge) begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        r_rx_shift <= w_rx_next;
        if (w_advance) begin
          r_mosi     <= r_cpha_l ? w_tx_cur : w_tx_next;
          r_tx_shift <= w_tx_shifted;
        end
        if (w_last_edge) begin
          r_rx_data <= w_rx_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - self-checking bench for spi_shift_engine with a divide-by-4 clock source.
// Expectations follow SPI_LSB_FIRST_EN when it is defined for the build.
module tb_spi_shift_engine;

  logic       clk_in = 1'b0;
  logic       sync_rst;
  logic       cpol;
  logic       cpha;
  logic       sclk_in = 1'b0;
  logic       clk_en_out;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  logic       loopback;
  logic       miso_tie;
  logic [1:0] div_cnt = 2'd0;

  int n_checks = 0;
  int n_pass   = 0;

  spi_shift_engine #(.DATA_WIDTH(8)) dut (
    .clk_in     (clk_in),
    .sync_rst   (sync_rst),
    .cpol       (cpol),
    .cpha       (cpha),
    .sclk_in    (sclk_in),
    .clk_en_out (clk_en_out),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n)
  );

  always #5 clk_in = ~clk_in;

  assign miso = loopback ? mosi : miso_tie;

  // Stand-in for clock_divider at ratio 4: each level is held for two clk_in cycles.
  always @(posedge clk_in) begin
    if (!clk_en_out) begin
      div_cnt <= 2'd0;
      sclk_in <= cpol;
    end else if (div_cnt == 2'd1) begin
      div_cnt <= 2'd0;
      sclk_in <= ~sclk_in;
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int k);
`ifdef SPI_LSB_FIRST_EN
    return w[k];
`else
    return w[7-k];
`endif
  endfunction

  // Transfer-level model: what each word must look like on the wire and at rx.
  logic       m_active = 1'b0;
  logic [7:0] m_word = 8'h00;
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] m_exp_rx = 8'h00;
  logic [7:0] m_cap = 8'h00;
  logic [7:0] last_cap = 8'h00;
  int         m_edges = 0;
  int         m_bits = 0;
  logic       pend_acc = 1'b0;
  logic       chk_rst = 1'b0;
  logic       post_done = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic       cmp_lead;
  int         cyc = 0;
  int         last_edge_cyc = 0;
  int         hi_cnt = 0;
  int         last_gap = 0;
  int         rx_count = 0;
  int         acc_count = 0;

  always @(negedge clk_in) begin
    cyc++;
    if (chk_rst) begin
      chk_rst = 1'b0;
      check1("rst_cs_n", cs_n, 1'b1);
      check1("rst_clk_en", clk_en_out, 1'b0);
      check1("rst_tx_ready", tx_ready, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_mosi", mosi, 1'b0);
      check1("rst_rx_valid", rx_valid, 1'b0);
      check8("rst_rx_data", rx_data, 8'h00);
      check1("rst_sclk", sclk, cpol);
    end
    if (sync_rst) begin
      chk_rst   = 1'b1;
      m_active  = 1'b0;
      pend_acc  = 1'b0;
      post_done = 1'b0;
    end else begin
      if (pend_acc) begin
        pend_acc = 1'b0;
        check1("acc_cs_n_low", cs_n, 1'b0);
        check1("acc_clk_en", clk_en_out, 1'b1);
        check1("acc_busy", busy, 1'b1);
        check1("acc_tx_ready", tx_ready, 1'b0);
      end
      if (post_done) begin
        post_done = 1'b0;
        check1("ready_after_done", tx_ready, 1'b1);
      end
      if (m_active && !cs_n && (sclk !== prev_sclk)) begin
        cmp_lead = (sclk != m_cpol);
        m_edges++;
        if (cmp_lead != m_cpha) begin
          check1("mosi_bit", mosi, exp_bit(m_word, m_bits & 7));
          check1("mosi_stable", mosi, prev_mosi);
          m_cap = {m_cap[6:0], mosi};
          m_bits++;
        end
        if (m_edges == 16) last_edge_cyc = cyc;
      end
      if (rx_valid) begin
        if (!m_active) begin
          check1("unexpected_rx_valid", 1'b1, 1'b0);
        end else begin
          check8("rx_data", rx_data, m_exp_rx);
          check1("done_cs_n", cs_n, 1'b1);
          check1("done_clk_en", clk_en_out, 1'b0);
          check1("done_sclk_idle", sclk, m_cpol);
          check_int("edge_count", m_edges, 16);
          check_int("sample_count", m_bits, 8);
          check_int("rx_latency", cyc - last_edge_cyc, 1);
        end
        m_active  = 1'b0;
        last_cap  = m_cap;
        rx_count++;
        post_done = 1'b1;
      end
      if (cs_n) begin
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        last_gap = hi_cnt;
        check1("cs_gap_min", hi_cnt >= 2, 1'b1);
        hi_cnt = 0;
      end
      if (tx_valid && tx_ready) begin
        m_active = 1'b1;
        pend_acc = 1'b1;
        m_word   = tx_data;
        m_cpol   = cpol;
        m_cpha   = cpha;
        m_exp_rx = loopback ? tx_data : {8{miso_tie}};
        m_edges  = 0;
        m_bits   = 0;
        m_cap    = 8'h00;
        acc_count++;
      end
    end
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_accept(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (tx_ready) got = 1'b1;
      step(1);
    end
    if (!got) check1(name, 1'b0, 1'b1);
  endtask

  task automatic wait_rx(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rx_valid) got = 1'b1;
      else step(1);
    end
    if (!got) check1(name, 1'b0, 1'b1);
  endtask

  task automatic wait_edges(input int n);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (m_edges >= n) got = 1'b1;
      else step(1);
    end
    if (!got) check1("edge_wait_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_xfer(input logic [7:0] d, input logic pol, input logic pha,
                         input logic lb, input logic tie);
    cpol     = pol;
    cpha     = pha;
    loopback = lb;
    miso_tie = tie;
    step(2);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_accept("accept_timeout");
    tx_valid = 1'b0;
    wait_rx("rx_timeout");
    step(2);
  endtask

  initial begin
    sync_rst = 1'b1;
    cpol     = 1'b0;
    cpha     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    loopback = 1'b1;
    miso_tie = 1'b0;
    step(3);
    sync_rst = 1'b0;
    step(2);

    // Mode 0, loopback
    do_xfer(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check8("mode0_mosi_word", last_cap, 8'hA5);
    check8("mode0_rx_data", rx_data, 8'hA5);

    // Mode 3, miso tied high
    do_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    check8("mode3_mosi_word", last_cap, 8'h3C);
    check8("mode3_rx_data", rx_data, 8'hFF);
    check1("mode3_idle_sclk", sclk, 1'b1);

    // Back-to-back with tx_valid held high
    cpol = 1'b0; cpha = 1'b0; loopback = 1'b1;
    step(2);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    wait_accept("b2b_accept1_timeout");
    tx_data = 8'h34;
    wait_rx("b2b_rx1_timeout");
    step(1);
`ifdef SPI_LSB_FIRST_EN
    check8("b2b_mosi_word1", last_cap, 8'h48);
`else
    check8("b2b_mosi_word1", last_cap, 8'h12);
`endif
    wait_accept("b2b_accept2_timeout");
    tx_valid = 1'b0;
    wait_rx("b2b_rx2_timeout");
    step(2);
`ifdef SPI_LSB_FIRST_EN
    check8("b2b_mosi_word2", last_cap, 8'h2C);
`else
    check8("b2b_mosi_word2", last_cap, 8'h34);
`endif
    check8("b2b_rx_data2", rx_data, 8'h34);
    check_int("b2b_cs_gap", last_gap, 2);
    check_int("b2b_rx_pulses", rx_count, 4);

    // Reset after the fifth edge
    step(2);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    wait_accept("rst_accept_timeout");
    tx_valid = 1'b0;
    wait_edges(5);
    sync_rst = 1'b1;
    step(1);
    sync_rst = 1'b0;
    check1("midrst_cs_n", cs_n, 1'b1);
    check1("midrst_clk_en", clk_en_out, 1'b0);
    check1("midrst_tx_ready", tx_ready, 1'b1);
    step(30);
    check_int("midrst_no_rx", rx_count, 4);
    do_xfer(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check8("post_rst_mosi_word", last_cap, 8'h5A);
    check8("post_rst_rx_data", rx_data, 8'h5A);

    // Live inputs change while busy
    cpol = 1'b0; cpha = 1'b0; loopback = 1'b1;
    step(2);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    wait_accept("busy_accept_timeout");
    tx_data = 8'h00;
    cpha    = 1'b1;
    wait_rx("busy_rx_timeout");
    tx_valid = 1'b0;
    cpha     = 1'b0;
    step(3);
    check8("busy_mosi_word", last_cap, 8'hC3);
    check8("busy_rx_data", rx_data, 8'hC3);
    check1("busy_no_extra_accept", busy, 1'b0);

    // Single set bit shows the shift order
    do_xfer(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SPI_LSB_FIRST_EN
    check8("order_mosi_word", last_cap, 8'h80);
`else
    check8("order_mosi_word", last_cap, 8'h01);
`endif
    check8("order_rx_data", rx_data, 8'h01);

    step(5);
    check_int("total_rx_pulses", rx_count, 7);
    check_int("total_accepts", acc_count, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
